traffic_light_ctrl: RTL and testbench



---
 rtl/tlc_pkg.sv | 28 ++
 rtl/tlc_phase_timer.sv | 35 +++
 rtl/traffic_light_ctrl.sv | 136 +++++++++++++
 tb/tb_traffic_light_ctrl.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/tlc_pkg.sv
// Shared phase encoding and lamp decode for the traffic-light controllers.
package tlc_pkg;

    typedef enum logic [2:0] {
        RED        = 3'd0,
        RED_YELLOW = 3'd1,
        GREEN      = 3'd2,
        YELLOW     = 3'd3,
        PED        = 3'd4,
        FLASH      = 3'd5
    } tlc_phase_e;

    localparam int LAMP_W = 4;

    // Lamp vector order is {red, yellow, green, walk}; FLASH gives the lit half of the blink.
    function automatic logic [LAMP_W-1:0] phase_lamps(tlc_phase_e ph);
        case (ph)
            RED:        return 4'b1000;
            RED_YELLOW: return 4'b1100;
            GREEN:      return 4'b0010;
            YELLOW:     return 4'b0100;
            PED:        return 4'b1001;
            FLASH:      return 4'b0100;
            default:    return 4'b1000;
        endcase
    endfunction

endpackage

// File: rtl/tlc_phase_timer.sv
// Phase down-counter: load a value, count to zero, flag expiry while at zero.
module tlc_phase_timer #(
    parameter int               CNT_W   = 8,
    parameter logic [CNT_W-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] value,
    output logic             expire
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = value;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= RST_VAL;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire = (cnt_q == '0);

endmodule

// File: rtl/traffic_light_ctrl.sv
// Vehicle/pedestrian traffic-light controller with parametrised phase lengths.
// Night flashing mode is built only when TLC_NIGHT_MODE_EN is defined.
//
//   state      | meaning
//   RED        | vehicles stop
//   RED_YELLOW | vehicles prepare to go
//   GREEN      | vehicles go
//   YELLOW     | vehicles prepare to stop
//   PED        | all-red, pedestrian walk lamp on
//   FLASH      | night mode, yellow blinking
module traffic_light_ctrl
    import tlc_pkg::*;
#(
    parameter int RED_CYCLES        = 4,
    parameter int RED_YELLOW_CYCLES = 1,
    parameter int GREEN_CYCLES      = 4,
    parameter int YELLOW_CYCLES     = 1,
    parameter int PED_CYCLES        = 6,
    parameter int FLASH_CYCLES      = 2,
    parameter int CNT_W             = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ped_req,
`ifdef TLC_NIGHT_MODE_EN
    input  logic       night,
`endif
    output logic       red,
    output logic       yellow,
    output logic       green,
    output logic       ped_walk,
    output logic       ped_pending,
    output logic [2:0] phase
);

    tlc_phase_e              state_q;
    tlc_phase_e              state_d;
    logic                    ped_pending_q;
    logic                    ped_pending_d;
    logic                    expire;
    logic [CNT_W-1:0]        load_val;
    logic [LAMP_W-1:0]       lamps;
`ifdef TLC_NIGHT_MODE_EN
    logic                    flash_on_q;
    logic                    flash_on_d;
`endif

    function automatic logic [CNT_W-1:0] phase_load(tlc_phase_e ph);
        case (ph)
            RED:        return CNT_W'(RED_CYCLES - 1);
            RED_YELLOW: return CNT_W'(RED_YELLOW_CYCLES - 1);
            GREEN:      return CNT_W'(GREEN_CYCLES - 1);
            YELLOW:     return CNT_W'(YELLOW_CYCLES - 1);
            PED:        return CNT_W'(PED_CYCLES - 1);
            FLASH:      return CNT_W'(FLASH_CYCLES - 1);
            default:    return CNT_W'(RED_CYCLES - 1);
        endcase
    endfunction

    // Reloaded on every expiry, including FLASH -> FLASH, so each phase lasts its full count.
    tlc_phase_timer #(
        .CNT_W   (CNT_W),
        .RST_VAL (CNT_W'(RED_CYCLES - 1))
    ) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (expire),
        .value  (load_val),
        .expire (expire)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= RED;
            ped_pending_q <= 1'b0;
`ifdef TLC_NIGHT_MODE_EN
            flash_on_q    <= 1'b1;
`endif
        end else begin
            state_q       <= state_d;
            ped_pending_q <= ped_pending_d;
`ifdef TLC_NIGHT_MODE_EN
            flash_on_q    <= flash_on_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        if (expire) begin
            case (state_q)
                RED:        state_d = RED_YELLOW;
                RED_YELLOW: state_d = GREEN;
                GREEN:      state_d = YELLOW;
                YELLOW:     state_d = (ped_pending_q || ped_req) ? PED : RED;
                PED:        state_d = RED_YELLOW;
                default:    state_d = RED;
            endcase
`ifdef TLC_NIGHT_MODE_EN
            if (night) begin
                state_d = FLASH;
            end
`endif
        end
        load_val = phase_load(state_d);

        // A request on the last YELLOW clock goes straight to PED, so clearing wins over setting.
        ped_pending_d = ped_pending_q;
        if (state_d == PED || state_d == FLASH || state_q == FLASH) begin
            ped_pending_d = 1'b0;
        end else if (ped_req && (state_q inside {RED, RED_YELLOW, GREEN, YELLOW})) begin
            ped_pending_d = 1'b1;
        end

`ifdef TLC_NIGHT_MODE_EN
        flash_on_d = flash_on_q;
        if (expire && state_d == FLASH) begin
            flash_on_d = (state_q == FLASH) ? ~flash_on_q : 1'b1;
        end
`endif
    end

    always_comb begin
        lamps = phase_lamps(state_q);
`ifdef TLC_NIGHT_MODE_EN
        if (state_q == FLASH) begin
            lamps[2] = flash_on_q;
        end
`endif
    end

    assign {red, yellow, green, ped_walk} = lamps;
    assign ped_pending = ped_pending_q;
    assign phase       = state_q;

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Self-checking bench for traffic_light_ctrl: per-clock expectation tables plus reset/night sequences.
module tb_traffic_light_ctrl;

    localparam logic [2:0] P_RED = 3'd0, P_RY = 3'd1, P_G = 3'd2, P_Y = 3'd3, P_PED = 3'd4, P_FL = 3'd5;

    typedef struct {
        logic       req;
        logic       nt;
        logic [2:0] ph;
        logic [3:0] lamps;
        logic       pend;
    } vec_t;

    logic       clk;
    logic       rst_n;
    logic       ped_req;
`ifdef TLC_NIGHT_MODE_EN
    logic       night;
`endif
    logic       red, yellow, green, ped_walk, ped_pending;
    logic [2:0] phase;

    vec_t vecs [0:255];
    int   n_vec;
    vec_t exp_q [$];
    int   total;
    int   bad;

    traffic_light_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ped_req     (ped_req),
`ifdef TLC_NIGHT_MODE_EN
        .night       (night),
`endif
        .red         (red),
        .yellow      (yellow),
        .green       (green),
        .ped_walk    (ped_walk),
        .ped_pending (ped_pending),
        .phase       (phase)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {red, yellow, green, walk} as the lamp table defines it
    function automatic logic [3:0] exp_lamps(logic [2:0] ph);
        case (ph)
            P_RED:   return 4'b1000;
            P_RY:    return 4'b1100;
            P_G:     return 4'b0010;
            P_Y:     return 4'b0100;
            P_PED:   return 4'b1001;
            default: return 4'b0100;
        endcase
    endfunction

    task automatic seg(input logic [2:0] ph, input int n, input logic pend);
        for (int i = 0; i < n; i++) begin
            vecs[n_vec].req   = 1'b0;
            vecs[n_vec].nt    = 1'b0;
            vecs[n_vec].ph    = ph;
            vecs[n_vec].lamps = exp_lamps(ph);
            vecs[n_vec].pend  = pend;
            n_vec++;
        end
    endtask

    task automatic seg_flash(input logic lit, input int n, input logic nt);
        for (int i = 0; i < n; i++) begin
            vecs[n_vec].req   = 1'b0;
            vecs[n_vec].nt    = nt;
            vecs[n_vec].ph    = P_FL;
            vecs[n_vec].lamps = {1'b0, lit, 2'b00};
            vecs[n_vec].pend  = 1'b0;
            n_vec++;
        end
    endtask

    task automatic push_exp(input logic [2:0] ph);
        vec_t v;
        v.req = 1'b0; v.nt = 1'b0; v.ph = ph; v.lamps = exp_lamps(ph); v.pend = 1'b0;
        exp_q.push_back(v);
    endtask

    task automatic check(input string name);
        vec_t e;
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL %s: scoreboard empty, nothing to compare against", name);
        end else begin
            e = exp_q.pop_front();
            if ({phase, red, yellow, green, ped_walk, ped_pending} !== {e.ph, e.lamps, e.pend}) begin
                bad++;
                $display("FAIL %s @%0t: got phase=%0d rygw=%b pend=%b, want phase=%0d rygw=%b pend=%b",
                         name, $time, phase, {red, yellow, green, ped_walk}, ped_pending,
                         e.ph, e.lamps, e.pend);
            end
        end
    endtask

    // Called at a negedge whose sample belongs to vecs[from].
    task automatic run_table(input int from, input int to, input string name);
        for (int i = from; i < to; i++) begin
            exp_q.push_back(vecs[i]);
            check($sformatf("%s[%0d]", name, i - from));
            ped_req = vecs[i].req;
`ifdef TLC_NIGHT_MODE_EN
            night = vecs[i].nt;
`endif
            @(negedge clk);
        end
        ped_req = 1'b0;
    endtask

    initial begin
        int t1_end, g0, p0, y0;
        total   = 0;
        bad     = 0;
        n_vec   = 0;
        rst_n   = 1'b0;
        ped_req = 1'b0;
`ifdef TLC_NIGHT_MODE_EN
        night   = 1'b0;
`endif

        // Two plain periods
        for (int k = 0; k < 2; k++) begin
            seg(P_RED, 4, 0); seg(P_RY, 1, 0); seg(P_G, 4, 0); seg(P_Y, 1, 0);
        end
        // Single pulse in the 2nd GREEN clock
        seg(P_RED, 4, 0); seg(P_RY, 1, 0);
        g0 = n_vec;
        seg(P_G, 2, 0); seg(P_G, 2, 1); seg(P_Y, 1, 1);
        vecs[g0 + 1].req = 1'b1;
        seg(P_PED, 6, 0); seg(P_RY, 1, 0);
        // Three pulses in one GREEN plus one during PED: single walk, then a normal cycle
        g0 = n_vec;
        seg(P_G, 1, 0); seg(P_G, 3, 1); seg(P_Y, 1, 1);
        vecs[g0].req = 1'b1; vecs[g0 + 1].req = 1'b1; vecs[g0 + 3].req = 1'b1;
        p0 = n_vec;
        seg(P_PED, 6, 0);
        vecs[p0 + 2].req = 1'b1;
        seg(P_RY, 1, 0); seg(P_G, 4, 0); seg(P_Y, 1, 0); seg(P_RED, 4, 0);
        // Request only on the last YELLOW clock
        seg(P_RY, 1, 0); seg(P_G, 4, 0);
        y0 = n_vec;
        seg(P_Y, 1, 0);
        vecs[y0].req = 1'b1;
        seg(P_PED, 6, 0); seg(P_RY, 1, 0); seg(P_G, 4, 0); seg(P_Y, 1, 0); seg(P_RED, 4, 0);
        t1_end = n_vec;

        @(negedge clk);
        push_exp(P_RED);
        check("reset_state");
        @(negedge clk);
        rst_n = 1'b1;
        run_table(0, t1_end, "seq");

        // Asynchronous reset pulse in the middle of GREEN
        push_exp(P_RY); check("pre_rst_ry");
        @(negedge clk); push_exp(P_G); check("pre_rst_g1");
        @(negedge clk); push_exp(P_G); check("pre_rst_g2");
        #2 rst_n = 1'b0;
        #1 push_exp(P_RED); check("async_rst");
        #9 rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); push_exp(P_RED); check($sformatf("post_rst_red%0d", i));
        end
        @(negedge clk); push_exp(P_RY); check("post_rst_ry");
        @(negedge clk);

`ifdef TLC_NIGHT_MODE_EN
        begin
            int n0, f0;
            n0 = n_vec;
            seg(P_G, 1, 0); seg(P_G, 3, 0);
            for (int i = n0 + 1; i < n_vec; i++) vecs[i].nt = 1'b1;
            seg_flash(1'b1, 2, 1'b1);
            f0 = n_vec;
            seg_flash(1'b0, 2, 1'b1);
            vecs[f0].req = 1'b1;
            seg_flash(1'b1, 2, 1'b0);
            seg(P_RED, 4, 0); seg(P_RY, 1, 0); seg(P_G, 4, 0); seg(P_Y, 1, 0); seg(P_RED, 1, 0);
            run_table(n0, n_vec, "night");
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
